l2_tlb_ram_ctrl: RTL and testbench
==================================

// Module: l2_tlb_ram_ctrl
// PURPOSE
//  Access controller for the single-port L2 TLB data array (1024x44, 1-cycle read, rdata valid only the cycle after a read).
//  Arbitrates lookups, refill writes and a full-array invalidate sweep onto the one RW port.
//  Performs the tag compare and returns a registered hit/miss response.
//  Sits between the PTW/L1-miss path (upstream) and the L2 TLB SRAM macro (downstream); the SRAM is clocked by `clock`.
// PARAMETERS
//  ENTRIES  1024  number of SRAM rows (power of two)
//  IDX_W    10    $clog2(ENTRIES)
//  TAG_W    17    stored tag width
//  DATA_W   26    stored payload width (PPN/perm bits, opaque here)
//  ENTRY_W  44    1+TAG_W+DATA_W; must equal SRAM word width
// PORTS
//  clock        in   1        clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  req_valid    in   1        lookup request
//  req_ready    out  1        lookup accepted when valid&ready
//  req_index    in   IDX_W    row to read
//  req_tag      in   TAG_W    tag to compare
//  resp_valid   out  1        response held until resp_ready
//  resp_ready   in   1        consumer accepts response
//  resp_hit     out  1        row valid and tag match
//  resp_data    out  DATA_W   payload of row (defined only when resp_hit)
//  refill_valid in   1        write request
//  refill_ready out  1        = ~flush_busy
//  refill_index in   IDX_W    row to write
//  refill_tag   in   TAG_W    tag to store
//  refill_data  in   DATA_W   payload to store
//  flush_req    in   1        one-cycle pulse: invalidate all rows
//  flush_busy   out  1        sweep in progress
//  ram_addr     out  IDX_W    SRAM address
//  ram_en       out  1        SRAM enable
//  ram_wmode    out  1        1 = write, 0 = read
//  ram_wdata    out  ENTRY_W  {valid, tag, data}, valid at MSB
//  ram_rdata    in   ENTRY_W  SRAM read data, cycle after read
// BEHAVIOUR
//  Reset: state=FLUSH, sweep_idx=0, s1_valid=0, resp_valid=0, resp_hit=0, resp_data=0; ram_en forced 0 while reset high.
//  FSM: FLUSH -> IDLE when sweep_idx==ENTRIES-1 written; IDLE -> FLUSH on flush_req.
//  FLUSH: each cycle write ENTRY_W'0 at sweep_idx, sweep_idx++; exactly ENTRIES cycles; flush_busy=1; req_ready=refill_ready=0.
//  flush_req while in FLUSH is absorbed (no restart). An in-flight s1 lookup always completes, even if FLUSH starts.
//  Port priority per cycle: FLUSH write > refill write > lookup read. Refill: ram_en=1, wmode=1, wdata={1,tag,data}.
//  req_ready = IDLE & ~refill_valid & ~s1_valid & (~resp_valid | resp_ready); max throughput one lookup per 2 cycles.
//  Lookup fire at cycle N: ram_en=1, wmode=0, ram_addr=req_index; s1_tag<=req_tag.
//  N+1: compare ram_rdata[43]&(ram_rdata[42:26]==s1_tag); register into resp; resp_valid=1 at N+2.
//  resp_* hold stable while resp_valid & ~resp_ready; clear on handshake.
//  Refill to same index as in-flight lookup: lookup returns pre-write contents (read-before-write).
//  Refill accepted in cycle a lookup is in s1: legal; does not disturb s1 data.
//  ram_addr/ram_en/ram_wmode/ram_wdata are combinational from state and inputs; ram_en=0 when idle.
//  Reset asserted mid-operation: in-flight lookup and pending response discarded; sweep restarts at 0.
// STRUCTURE
//  Package l2_tlb_pkg: ENTRIES, IDX_W, TAG_W, DATA_W, ENTRY_W; packed struct l2_tlb_entry_t {valid, tag, data}; enum state_e {FLUSH, IDLE}.
//  Sub-module l2_tlb_flush_sweeper: sweep counter + busy/done flags; rest (arbiter, s1, resp reg, compare) flat in l2_tlb_ram_ctrl.
// TESTING
//  Reset release -> flush_busy=1 for 1024 cycles, writes of 0 at rows 0..1023 in order, then req_ready=1.
//  Refill idx 5 tag 0x1ABCD data 0x1234567; lookup idx 5 tag 0x1ABCD -> resp_valid 2 cycles after fire, hit=1, data=0x1234567.
//  Lookup idx 5 tag 0x00001 -> hit=0; lookup idx 6 (never written) -> hit=0.
//  refill_valid & req_valid same cycle -> refill written, req_ready=0; lookup fires next cycle and sees new entry.
//  resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0; resp_ready=1 -> handshake, next lookup accepted.
//  flush_req with lookup in s1 -> that lookup responds normally; after sweep, lookup idx 5 misses; reset mid-sweep -> sweep restarts at 0.

Source files
------------

// File: rtl/l2_tlb_pkg.sv
// Shared widths, entry layout and controller state encoding for the L2 TLB RAM controller.
package l2_tlb_pkg;

  localparam int unsigned ENTRIES = 1024;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 17;
  localparam int unsigned DATA_W  = 26;
  localparam int unsigned ENTRY_W = 1 + TAG_W + DATA_W;

  // Valid bit sits at the MSB of the SRAM word.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } l2_tlb_entry_t;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic l2_tlb_entry_t make_entry(input logic [TAG_W-1:0]  tag,
                                               input logic [DATA_W-1:0] data);
    l2_tlb_entry_t e;
    e.valid = 1'b1;
    e.tag   = tag;
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/l2_tlb_ram_ctrl_if.sv
// Upstream lookup/refill/flush handshakes plus the SRAM port, bundled for the controller.
interface l2_tlb_ram_ctrl_if;
  import l2_tlb_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_index;
  logic [TAG_W-1:0]   req_tag;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic [DATA_W-1:0]  resp_data;

  logic               refill_valid;
  logic               refill_ready;
  logic [IDX_W-1:0]   refill_index;
  logic [TAG_W-1:0]   refill_tag;
  logic [DATA_W-1:0]  refill_data;

  logic               flush_req;
  logic               flush_busy;

  logic [IDX_W-1:0]   ram_addr;
  logic               ram_en;
  logic               ram_wmode;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  // Controller side.
  modport slave (
    input  req_valid, req_index, req_tag,
    output req_ready,
    output resp_valid, resp_hit, resp_data,
    input  resp_ready,
    input  refill_valid, refill_index, refill_tag, refill_data,
    output refill_ready,
    input  flush_req,
    output flush_busy,
    output ram_addr, ram_en, ram_wmode, ram_wdata,
    input  ram_rdata
  );

  // Requester / SRAM side.
  modport master (
    output req_valid, req_index, req_tag,
    input  req_ready,
    input  resp_valid, resp_hit, resp_data,
    output resp_ready,
    output refill_valid, refill_index, refill_tag, refill_data,
    input  refill_ready,
    output flush_req,
    input  flush_busy,
    input  ram_addr, ram_en, ram_wmode, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/l2_tlb_flush_sweeper.sv
// Row counter for the invalidate sweep; flags the cycle that writes the last row.
module l2_tlb_flush_sweeper
  import l2_tlb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_active,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_busy,
  output logic             o_done
);

  logic [IDX_W-1:0] r_idx;

  // Wraps to zero after the last row, so the next sweep starts clean.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (i_active) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  assign o_busy = i_active;
  assign o_done = i_active && (r_idx == IDX_W'(ENTRIES - 1));

endmodule

// File: rtl/l2_tlb_ram_ctrl.sv
// L2 TLB single-port SRAM controller: flush sweep, refill writes, lookups with registered
// tag compare and a held response.
module l2_tlb_ram_ctrl
  import l2_tlb_pkg::*;
(
  input logic                clock,
  input logic                reset,
  l2_tlb_ram_ctrl_if.slave   io_bus
);

  state_e r_state;
  state_e w_state_next;

  logic             w_flushing;
  logic [IDX_W-1:0] w_sweep_idx;
  logic             w_sweep_busy;
  logic             w_sweep_done;

  logic             w_req_ready;
  logic             w_req_fire;

  logic               w_ram_en;
  logic               w_ram_wmode;
  logic [IDX_W-1:0]   w_ram_addr;
  logic [ENTRY_W-1:0] w_ram_wdata;

  logic             r_s1_valid;
  logic [TAG_W-1:0] r_s1_tag;

  l2_tlb_entry_t    w_rd_entry;
  logic             w_hit;

  logic              r_resp_valid;
  logic              r_resp_hit;
  logic [DATA_W-1:0] r_resp_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= FLUSH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A flush request during a sweep is absorbed rather than restarting it.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FLUSH: if (w_sweep_done) w_state_next = IDLE;
      IDLE:  if (io_bus.flush_req) w_state_next = FLUSH;
      default: w_state_next = FLUSH;
    endcase
  end

  assign w_flushing = (r_state == FLUSH);

  l2_tlb_flush_sweeper u_sweeper (
    .clock    (clock),
    .reset    (reset),
    .i_active (w_flushing),
    .o_idx    (w_sweep_idx),
    .o_busy   (w_sweep_busy),
    .o_done   (w_sweep_done)
  );

  // One lookup outstanding at a time; refill pre-empts the read port.
  assign w_req_ready = (r_state == IDLE) && !io_bus.refill_valid && !r_s1_valid &&
                       (!r_resp_valid || io_bus.resp_ready);
  assign w_req_fire  = io_bus.req_valid && w_req_ready;

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_wmode = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (w_sweep_busy) begin
      w_ram_en    = 1'b1;
      w_ram_wmode = 1'b1;
      w_ram_addr  = w_sweep_idx;
    end else if (io_bus.refill_valid) begin
      w_ram_en    = 1'b1;
      w_ram_wmode = 1'b1;
      w_ram_addr  = io_bus.refill_index;
      w_ram_wdata = make_entry(io_bus.refill_tag, io_bus.refill_data);
    end else if (w_req_fire) begin
      w_ram_en    = 1'b1;
      w_ram_addr  = io_bus.req_index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= w_req_fire;
      if (w_req_fire) begin
        r_s1_tag <= io_bus.req_tag;
      end
    end
  end

  assign w_rd_entry = l2_tlb_entry_t'(io_bus.ram_rdata);
  assign w_hit      = w_rd_entry.valid && (w_rd_entry.tag == r_s1_tag);

  // s1 only completes into an empty (or draining) response slot, guaranteed by w_req_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_data  <= '0;
    end else if (r_s1_valid) begin
      r_resp_valid <= 1'b1;
      r_resp_hit   <= w_hit;
      r_resp_data  <= w_hit ? w_rd_entry.data : '0;
    end else if (r_resp_valid && io_bus.resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_data  <= '0;
    end
  end

  assign io_bus.req_ready    = w_req_ready;
  assign io_bus.resp_valid   = r_resp_valid;
  assign io_bus.resp_hit     = r_resp_hit;
  assign io_bus.resp_data    = r_resp_data;
  assign io_bus.refill_ready = !w_sweep_busy;
  assign io_bus.flush_busy   = w_sweep_busy;

  assign io_bus.ram_en    = w_ram_en && !reset;
  assign io_bus.ram_wmode = w_ram_wmode;
  assign io_bus.ram_addr  = w_ram_addr;
  assign io_bus.ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_l2_tlb_ram_ctrl.sv
// Directed bench for l2_tlb_ram_ctrl with an SRAM model and a table-level reference model.
module tb_l2_tlb_ram_ctrl;

  logic clock;
  logic reset;

  l2_tlb_ram_ctrl_if bus ();

  l2_tlb_ram_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // SRAM: 1-cycle read, data meaningful only the cycle after a read.
  logic [43:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 44'({$urandom(), $urandom()});
  end
  always @(posedge clock) begin
    if (bus.ram_en && bus.ram_wmode) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_wmode) bus.ram_rdata <= mem[bus.ram_addr];
    else bus.ram_rdata <= 44'({$urandom(), $urandom()});
  end

  // Reference model: table contents, sweep progress, expected responses.
  typedef struct {
    logic        hit;
    logic [25:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic        m_v    [1024];
  logic [16:0] m_tag  [1024];
  logic [25:0] m_data [1024];
  logic        m_flush;
  int          m_sweep;
  logic        m_s1;
  int          cyc;

  initial begin
    logic exp_rv, exp_rr, fire;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        check("rst_ram_en", 64'(bus.ram_en), 64'(0));
        check("rst_busy", 64'(bus.flush_busy), 64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_hit", 64'(bus.resp_hit), 64'(0));
        check("rst_resp_data", 64'(bus.resp_data), 64'(0));
        q.delete();
        for (int i = 0; i < 1024; i++) m_v[i] = 1'b0;
        m_flush = 1'b1;
        m_sweep = 0;
        m_s1    = 1'b0;
        continue;
      end
      exp_rv = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      fire   = 1'b0;
      check("flush_busy", 64'(bus.flush_busy), 64'(m_flush));
      if (m_flush) begin
        check("flush_req_ready", 64'(bus.req_ready), 64'(0));
        check("flush_refill_ready", 64'(bus.refill_ready), 64'(0));
        check("sweep_en", 64'(bus.ram_en), 64'(1));
        check("sweep_wmode", 64'(bus.ram_wmode), 64'(1));
        check("sweep_wdata", 64'(bus.ram_wdata), 64'(0));
        check("sweep_addr", 64'(bus.ram_addr), 64'(m_sweep));
        m_sweep++;
        if (m_sweep == 1024) begin
          m_flush = 1'b0;
          m_sweep = 0;
        end
      end else begin
        exp_rr = !bus.refill_valid && !m_s1 && (!exp_rv || bus.resp_ready);
        check("refill_ready", 64'(bus.refill_ready), 64'(1));
        check("req_ready", 64'(bus.req_ready), 64'(exp_rr));
        fire = bus.req_valid && bus.req_ready;
        if (bus.refill_valid) begin
          check("refill_en", 64'(bus.ram_en), 64'(1));
          check("refill_wmode", 64'(bus.ram_wmode), 64'(1));
          check("refill_addr", 64'(bus.ram_addr), 64'(bus.refill_index));
          check("refill_wdata", 64'(bus.ram_wdata),
                64'({1'b1, bus.refill_tag, bus.refill_data}));
        end else if (fire) begin
          check("read_en", 64'(bus.ram_en), 64'(1));
          check("read_wmode", 64'(bus.ram_wmode), 64'(0));
          check("read_addr", 64'(bus.ram_addr), 64'(bus.req_index));
        end else begin
          check("ram_quiet", 64'(bus.ram_en), 64'(0));
        end
        if (fire) begin
          e.hit  = m_v[bus.req_index] && (m_tag[bus.req_index] == bus.req_tag);
          e.data = m_data[bus.req_index];
          e.cyc  = cyc;
          q.push_back(e);
        end
        if (bus.refill_valid) begin
          m_v[bus.refill_index]    = 1'b1;
          m_tag[bus.refill_index]  = bus.refill_tag;
          m_data[bus.refill_index] = bus.refill_data;
        end
        if (bus.flush_req) begin
          for (int i = 0; i < 1024; i++) m_v[i] = 1'b0;
          m_flush = 1'b1;
          m_sweep = 0;
        end
      end
      check("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
      if (exp_rv && bus.resp_valid) begin
        check("resp_hit", 64'(bus.resp_hit), 64'(q[0].hit));
        if (q[0].hit) check("resp_data", 64'(bus.resp_data), 64'(q[0].data));
        if (bus.resp_ready) void'(q.pop_front());
      end
      m_s1 = fire;
    end
  end

  // Stimulus helpers; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fire_req(input logic [9:0] idx, input logic [16:0] tag);
    logic fired;
    fired = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.req_tag   = tag;
    for (int i = 0; i < 50 && !fired; i++) begin
      @(negedge clock);
      fired = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!fired) check("req_fire_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_resp(output logic hit, output logic [25:0] data);
    logic got;
    got  = 1'b0;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = bus.resp_valid;
    end
    if (!got) check("resp_timeout", 64'(0), 64'(1));
    hit  = bus.resp_hit;
    data = bus.resp_data;
  endtask

  task automatic lookup(input logic [9:0] idx, input logic [16:0] tag,
                        output logic hit, output logic [25:0] data);
    fire_req(idx, tag);
    wait_resp(hit, data);
    tick();
  endtask

  task automatic refill(input logic [9:0] idx, input logic [16:0] tag, input logic [25:0] d);
    bus.refill_valid = 1'b1;
    bus.refill_index = idx;
    bus.refill_tag   = tag;
    bus.refill_data  = d;
    @(negedge clock);
    check("refill_accept", 64'(bus.refill_ready), 64'(1));
    tick();
    bus.refill_valid = 1'b0;
  endtask

  task automatic wait_sweep(input string name, input bit check_len);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (!bus.flush_busy) break;
      cnt++;
    end
    if (check_len) check(name, 64'(cnt), 64'(1024));
    else if (bus.flush_busy) check(name, 64'(1), 64'(0));
    tick();
  endtask

  initial begin
    logic        hit;
    logic [25:0] data;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_index    = '0;
    bus.req_tag      = '0;
    bus.resp_ready   = 1'b1;
    bus.refill_valid = 1'b0;
    bus.refill_index = '0;
    bus.refill_tag   = '0;
    bus.refill_data  = '0;
    bus.flush_req    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    wait_sweep("init_sweep_len", 1'b1);
    check("idle_req_ready", 64'(bus.req_ready), 64'(1));

    refill(10'd5, 17'h1ABCD, 26'h1234567);
    fire_req(10'd5, 17'h1ABCD);
    @(negedge clock);
    check("lat_cycle1", 64'(bus.resp_valid), 64'(0));
    tick();
    @(negedge clock);
    check("lat_cycle2", 64'(bus.resp_valid), 64'(1));
    check("hit5", 64'(bus.resp_hit), 64'(1));
    check("data5", 64'(bus.resp_data), 64'(26'h1234567));
    tick();

    lookup(10'd5, 17'h00001, hit, data);
    check("miss5_tag", 64'(hit), 64'(0));
    lookup(10'd6, 17'h1ABCD, hit, data);
    check("miss6", 64'(hit), 64'(0));
    lookup(10'd6, 17'h00000, hit, data);
    check("miss6_zero_tag", 64'(hit), 64'(0));

    // Refill and lookup presented together: refill wins, lookup follows.
    bus.refill_valid = 1'b1;
    bus.refill_index = 10'd7;
    bus.refill_tag   = 17'h00F0F;
    bus.refill_data  = 26'h2AAAAAA;
    bus.req_valid    = 1'b1;
    bus.req_index    = 10'd7;
    bus.req_tag      = 17'h00F0F;
    @(negedge clock);
    check("collide_req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    bus.refill_valid = 1'b0;
    lookup(10'd7, 17'h00F0F, hit, data);
    check("collide_hit", 64'(hit), 64'(1));
    check("collide_data", 64'(data), 64'(26'h2AAAAAA));

    // Back-pressure.
    bus.resp_ready = 1'b0;
    fire_req(10'd5, 17'h1ABCD);
    wait_resp(hit, data);
    bus.req_valid = 1'b1;
    bus.req_index = 10'd7;
    bus.req_tag   = 17'h00F0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clock);
      check("stall_req_ready", 64'(bus.req_ready), 64'(0));
      check("stall_hit", 64'(bus.resp_hit), 64'(1));
      check("stall_data", 64'(bus.resp_data), 64'(26'h1234567));
    end
    tick();
    bus.resp_ready = 1'b1;
    lookup(10'd7, 17'h00F0F, hit, data);
    check("after_stall_hit", 64'(hit), 64'(1));

    // Refill to the row of a lookup sitting in s1: lookup sees old contents.
    refill(10'd9, 17'h11111, 26'h0000001);
    fire_req(10'd9, 17'h11111);
    refill(10'd9, 17'h22222, 26'h3FFFFFF);
    wait_resp(hit, data);
    check("rbw_hit", 64'(hit), 64'(1));
    check("rbw_data", 64'(data), 64'(26'h0000001));
    tick();
    lookup(10'd9, 17'h22222, hit, data);
    check("rbw_new_data", 64'(data), 64'(26'h3FFFFFF));

    // Flush with a lookup in s1; a second request mid-sweep is absorbed.
    fire_req(10'd5, 17'h1ABCD);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    wait_resp(hit, data);
    check("flush_s1_hit", 64'(hit), 64'(1));
    check("flush_s1_data", 64'(data), 64'(26'h1234567));
    tick();
    repeat (100) tick();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    wait_sweep("flush_done", 1'b0);
    lookup(10'd5, 17'h1ABCD, hit, data);
    check("post_flush_miss5", 64'(hit), 64'(0));

    // Reset discards a pending response and restarts the sweep.
    bus.resp_ready = 1'b0;
    fire_req(10'd7, 17'h00F0F);
    wait_resp(hit, data);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rst_drop_resp", 64'(bus.resp_valid), 64'(0));
    tick();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("restart_addr0", 64'(bus.ram_addr), 64'(0));
    repeat (300) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midsweep_addr0", 64'(bus.ram_addr), 64'(0));
    tick();
    wait_sweep("midsweep_len", 1'b0);

    refill(10'd1023, 17'h1FFFF, 26'h0ABCDEF);
    lookup(10'd1023, 17'h1FFFF, hit, data);
    check("last_row_hit", 64'(hit), 64'(1));
    check("last_row_data", 64'(data), 64'(26'h0ABCDEF));
    lookup(10'd0, 17'h00000, hit, data);
    check("row0_miss", 64'(hit), 64'(0));

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
